equiv_stim_gen: RTL and testbench

//  Stimulus/driver end of the equivalence harness: generates pseudo-random input vectors
//  for the two DUT copies (wire0..wire3) and scores their 91-bit outputs (y_1, y_2).

---
 rtl/equiv_pkg.sv | 42 ++++
 rtl/equiv_lfsr.sv | 42 ++++
 rtl/equiv_stim_gen.sv | 183 ++++++++++++++++++
 tb/tb_equiv_stim_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
// equiv_pkg
//   Shared constants for the equivalence-harness stimulus generator.
//   - LFSR geometry and feedback taps
//   - stimulus slice widths/offsets for wire0..wire3
//   - DUT output width and the generator state enum
package equiv_pkg;

  localparam int LFSR_W = 40;
  localparam int Y_W    = 91;

  // Feedback taps as polynomial exponents: x^40 + x^38 + x^21 + x^19 + 1
  localparam int TAP_0 = 40;
  localparam int TAP_1 = 38;
  localparam int TAP_2 = 21;
  localparam int TAP_3 = 19;

  localparam int W0_LSB = 0;
  localparam int W0_W   = 4;
  localparam int W1_LSB = 4;
  localparam int W1_W   = 13;
  localparam int W2_LSB = 17;
  localparam int W2_W   = 4;
  localparam int W3_LSB = 21;
  localparam int W3_W   = 12;

  // Only the low LFSR bits feed the DUT inputs.
  localparam int STIM_W = W3_LSB + W3_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    logic fb;
    fb = cur[TAP_0-1] ^ cur[TAP_1-1] ^ cur[TAP_2-1] ^ cur[TAP_3-1];
    return {cur[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// equiv_lfsr
//   40-bit maximal Fibonacci LFSR used as the stimulus source.
//   Ports:
//     clk, rst_n  clock / async active-low reset (resets to all-ones)
//     load        load seed on next edge (all-zero seed becomes all-ones)
//     step        advance one position on next edge
//     seed        seed value
//     stim        low STIM_W bits of the current state
module equiv_lfsr
  import equiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [STIM_W-1:0] stim
);

  logic [LFSR_W-1:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      // All-zero is the lock-up state of an XOR LFSR.
      lfsr_d = (seed == '0) ? '1 : seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stim = lfsr_q[STIM_W-1:0];

endmodule

// File: rtl/equiv_stim_gen.sv
// equiv_stim_gen
//   Drives pseudo-random vectors into two DUT copies and scores their outputs.
//   Ports:
//     clk, rst_n        clock / async active-low reset
//     start             begin a run (accepted in IDLE/DONE only)
//     seed_load, seed   reseed the LFSR (accepted in IDLE/DONE only)
//     num_vec           vectors per run, captured on start
//     wire0..wire3      registered stimulus slices of the LFSR
//     y_1, y_2          outputs of the two DUT copies
//     busy, done        run in progress / run finished (held until next start)
//     fail, fail_idx    sticky mismatch flag and index of first mismatching vector
//     vec_cnt           vectors issued this run
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | issuing one vector per cycle
//   ST_DRAIN | no new vectors; waiting for the last responses to be scored
//   ST_DONE  | run complete, results held until the next start
module equiv_stim_gen
  import equiv_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DUT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [CNT_W-1:0]         num_vec,
  output logic signed [W0_W-1:0]   wire0,
  output logic [W1_W-1:0]          wire1,
  output logic signed [W2_W-1:0]   wire2,
  output logic signed [W3_W-1:0]   wire3,
  input  logic [Y_W-1:0]           y_1,
  input  logic [Y_W-1:0]           y_2,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [CNT_W-1:0]         fail_idx,
  output logic [CNT_W-1:0]         vec_cnt
);

  localparam int DRN_W = $clog2(DUT_LAT + 1);

  state_e                      state_d, state_q;
  logic [CNT_W-1:0]            num_vec_d, num_vec_q;
  logic [CNT_W-1:0]            vec_cnt_d, vec_cnt_q;
  logic [DRN_W-1:0]            drain_d, drain_q;
  logic signed [W0_W-1:0]      wire0_d, wire0_q;
  logic [W1_W-1:0]             wire1_d, wire1_q;
  logic signed [W2_W-1:0]      wire2_d, wire2_q;
  logic signed [W3_W-1:0]      wire3_d, wire3_q;
  logic                        fail_d, fail_q;
  logic [CNT_W-1:0]            fail_idx_d, fail_idx_q;
  logic                        busy_d, busy_q;
  logic                        done_d, done_q;
  // Stage 0 tags the vector currently on wire*; stage DUT_LAT lines up with y_1/y_2.
  logic [DUT_LAT:0]            tag_vld_d, tag_vld_q;
  logic [DUT_LAT:0][CNT_W-1:0] tag_idx_d, tag_idx_q;

  logic                        lfsr_load, lfsr_step;
  logic [STIM_W-1:0]           lfsr_stim;
  logic [CNT_W-1:0]            vec_cnt_inc;

  equiv_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .stim  (lfsr_stim)
  );

  assign vec_cnt_inc = vec_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    vec_cnt_d  = vec_cnt_q;
    drain_d    = drain_q;
    wire0_d    = wire0_q;
    wire1_d    = wire1_q;
    wire2_d    = wire2_q;
    wire3_d    = wire3_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    tag_vld_d  = {tag_vld_q[DUT_LAT-1:0], 1'b0};
    tag_idx_d  = {tag_idx_q[DUT_LAT-1:0], vec_cnt_q};

    if (tag_vld_q[DUT_LAT] && (y_1 != y_2) && !fail_q) begin
      fail_d     = 1'b1;
      fail_idx_d = tag_idx_q[DUT_LAT];
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        lfsr_load = seed_load;
        if (start) begin
          num_vec_d  = num_vec;
          vec_cnt_d  = '0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          state_d    = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_step    = 1'b1;
        wire0_d      = lfsr_stim[W0_LSB +: W0_W];
        wire1_d      = lfsr_stim[W1_LSB +: W1_W];
        wire2_d      = lfsr_stim[W2_LSB +: W2_W];
        wire3_d      = lfsr_stim[W3_LSB +: W3_W];
        vec_cnt_d    = vec_cnt_inc;
        tag_vld_d[0] = 1'b1;
        if (vec_cnt_inc == num_vec_q) begin
          state_d = ST_DRAIN;
          drain_d = DRN_W'(DUT_LAT);
        end
      end
      ST_DRAIN: begin
        // DUT_LAT cycles of DUT latency plus one for the scoring register,
        // so fail is final on the same edge done rises.
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_vec_q  <= '0;
      vec_cnt_q  <= '0;
      drain_q    <= '0;
      wire0_q    <= '0;
      wire1_q    <= '0;
      wire2_q    <= '0;
      wire3_q    <= '0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      vec_cnt_q  <= vec_cnt_d;
      drain_q    <= drain_d;
      wire0_q    <= wire0_d;
      wire1_q    <= wire1_d;
      wire2_q    <= wire2_d;
      wire3_q    <= wire3_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
    end
  end

  assign wire0    = wire0_q;
  assign wire1    = wire1_q;
  assign wire2    = wire2_q;
  assign wire3    = wire3_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign fail_idx = fail_idx_q;
  assign vec_cnt  = vec_cnt_q;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// tb_equiv_stim_gen
//   Drives equiv_stim_gen with randomized runs; two DUT copies are modelled in
//   the bench as a one-cycle registered function of the stimulus, with optional
//   single-bit corruption of copy 2 for chosen vector indices.
module tb_equiv_stim_gen;

  localparam int LAT = 1;
  localparam logic [39:0] TAP_MASK = (40'd1 << 39) | (40'd1 << 37) | (40'd1 << 20) | (40'd1 << 18);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              seed_load = 1'b0;
  logic [39:0]       seed = '0;
  logic [15:0]       num_vec = '0;
  logic signed [3:0]  wire0;
  logic [12:0]        wire1;
  logic signed [3:0]  wire2;
  logic signed [11:0] wire3;
  logic [90:0]       y_1 = '0;
  logic [90:0]       y_2 = '0;
  logic              busy, done, fail;
  logic [15:0]       fail_idx, vec_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [39:0] m_lfsr;
  logic [32:0] exp_q[$];
  bit          bad_mask[64];
  bit          bad_now = 1'b0;
  logic        exp_fail;
  int          exp_idx;

  // observations captured by run_capture
  logic [32:0] obs_vec[64];
  logic [15:0] obs_cnt[64];
  int          done_cyc, busy_end;
  logic        busy0, obs_fail, obs_done_hold;
  logic [15:0] obs_idx, obs_cnt_final;
  logic [32:0] obs_hold;

  equiv_stim_gen #(.CNT_W(16), .DUT_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .num_vec   (num_vec),
    .wire0     (wire0),
    .wire1     (wire1),
    .wire2     (wire2),
    .wire3     (wire3),
    .y_1       (y_1),
    .y_2       (y_2),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_idx  (fail_idx),
    .vec_cnt   (vec_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] cur_wires();
    return {wire3, wire2, wire1, wire0};
  endfunction

  function automatic logic [90:0] dut_fn(input logic [32:0] v);
    return {v, ~v, v[24:0]};
  endfunction

  // Two DUT copies with one register of latency; copy 2 flips bit 0 when told.
  always @(posedge clk) begin
    y_1 <= dut_fn(cur_wires());
    y_2 <= dut_fn(cur_wires()) ^ {90'd0, bad_now};
  end

  // Polynomial x^40+x^38+x^21+x^19+1: new bit is the parity of the tapped bits.
  function automatic logic [39:0] model_step(input logic [39:0] s);
    return {s[38:0], ^(s & TAP_MASK)};
  endfunction

  task automatic clear_mask();
    for (int i = 0; i < 64; i++) bad_mask[i] = 1'b0;
  endtask

  // Runs one start..done sequence, building expectations from the model and
  // recording what the generator did. No checking here.
  task automatic run_capture(input int n, input bit ld, input logic [39:0] sd, input bit poke);
    exp_q.delete();
    if (ld) m_lfsr = (sd == '0) ? '1 : sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_lfsr[32:0]);
      m_lfsr = model_step(m_lfsr);
    end
    exp_fail = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < n; i++) begin
      if (bad_mask[i] && !exp_fail) begin
        exp_fail = 1'b1;
        exp_idx  = i;
      end
    end
    seed = sd; seed_load = ld; num_vec = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    done_cyc = -1; busy_end = -1; busy0 = busy;
    for (int c = 0; c <= n + 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c >= 1 && c <= n) begin
        obs_vec[c-1] = cur_wires();
        obs_cnt[c-1] = vec_cnt;
      end
      bad_now = (c >= 1 && c <= n) ? bad_mask[c-1] : 1'b0;
      if (busy_end < 0 && !busy) busy_end = c;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        seed_load = 1'($urandom_range(0, 1));
        seed      = {8'($urandom), $urandom};
      end
    end
    start = 1'b0; seed_load = 1'b0; bad_now = 1'b0;
    obs_fail = fail; obs_idx = fail_idx; obs_cnt_final = vec_cnt;
    repeat (3) @(posedge clk);
    #1;
    obs_hold = cur_wires(); obs_done_hold = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cur_wires() !== 33'd0) begin n_bad++; $display("FAIL reset_wires: got %h want 0", cur_wires()); end
    n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got busy/done/fail %b want 000", {busy, done, fail}); end
    n_cmp++; if ({fail_idx, vec_cnt} !== 32'd0) begin n_bad++; $display("FAIL reset_counts: got idx %0d cnt %0d want 0", fail_idx, vec_cnt); end
    rst_n = 1'b1;
    m_lfsr = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_run();
    clear_mask();
    run_capture(4, 1'b1, 40'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL basic_vec%0d: got %h want %h", k, obs_vec[k], exp_q[k]); end
      n_cmp++; if (obs_cnt[k] !== 16'(k + 1)) begin n_bad++; $display("FAIL basic_cnt%0d: got %0d want %0d", k, obs_cnt[k], k + 1); end
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) begin
        n_cmp++; if (obs_vec[i] === obs_vec[j]) begin n_bad++; $display("FAIL basic_distinct: vec%0d == vec%0d = %h, want different", i, j, obs_vec[i]); end
      end
    n_cmp++; if (done_cyc !== 4 + LAT + 1) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, 4 + LAT + 1); end
    n_cmp++; if (busy_end !== 4 + LAT + 1) begin n_bad++; $display("FAIL basic_busy_end: got %0d want %0d", busy_end, 4 + LAT + 1); end
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b want 1", busy0); end
    n_cmp++; if (obs_fail !== 1'b0) begin n_bad++; $display("FAIL basic_fail: got %b want 0", obs_fail); end
    n_cmp++; if (obs_cnt_final !== 16'd4) begin n_bad++; $display("FAIL basic_final_cnt: got %0d want 4", obs_cnt_final); end
    n_cmp++; if (obs_hold !== exp_q[3]) begin n_bad++; $display("FAIL basic_hold: got %h want %h", obs_hold, exp_q[3]); end
    n_cmp++; if (obs_done_hold !== 1'b1) begin n_bad++; $display("FAIL basic_done_held: got %b want 1", obs_done_hold); end
  endtask

  task automatic test_zero_seed();
    clear_mask();
    run_capture(2, 1'b1, 40'd0, 1'b0);
    n_cmp++; if (obs_vec[0][3:0] !== 4'hF) begin n_bad++; $display("FAIL zseed_wire0: got %h want f", obs_vec[0][3:0]); end
    n_cmp++; if (obs_vec[0][16:4] !== 13'h1FFF) begin n_bad++; $display("FAIL zseed_wire1: got %h want 1fff", obs_vec[0][16:4]); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL zseed_vec%0d: got %h want %h", k, obs_vec[k], exp_q[k]); end
    end
  endtask

  task automatic test_single_mismatch();
    clear_mask();
    bad_mask[2] = 1'b1;
    run_capture(8, 1'b0, 40'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL single_vec%0d: got %h want %h", k, obs_vec[k], exp_q[k]); end
    end
    n_cmp++; if (obs_fail !== 1'b1) begin n_bad++; $display("FAIL single_fail: got %b want 1", obs_fail); end
    n_cmp++; if (obs_idx !== 16'd2) begin n_bad++; $display("FAIL single_idx: got %0d want 2", obs_idx); end
    n_cmp++; if (done_cyc !== 8 + LAT + 1) begin n_bad++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, 8 + LAT + 1); end
  endtask

  task automatic test_zero_count();
    logic [32:0] pre;
    clear_mask();
    pre = cur_wires();
    run_capture(0, 1'b0, 40'd0, 1'b0);
    n_cmp++; if (done_cyc !== 0) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 0", done_cyc); end
    n_cmp++; if (busy0 !== 1'b0 || busy_end !== 0) begin n_bad++; $display("FAIL zero_busy: got busy0 %b end %0d want 0 0", busy0, busy_end); end
    n_cmp++; if (obs_fail !== 1'b0 || obs_idx !== 16'd0) begin n_bad++; $display("FAIL zero_fail_clear: got %b idx %0d want 0 0", obs_fail, obs_idx); end
    n_cmp++; if (obs_cnt_final !== 16'd0) begin n_bad++; $display("FAIL zero_cnt: got %0d want 0", obs_cnt_final); end
    n_cmp++; if (obs_hold !== pre) begin n_bad++; $display("FAIL zero_wires_held: got %h want %h", obs_hold, pre); end
  endtask

  task automatic test_multi_mismatch();
    int n;
    clear_mask();
    bad_mask[3] = 1'b1;
    bad_mask[6] = 1'b1;
    run_capture(8, 1'b1, {8'($urandom), $urandom}, 1'b0);
    n_cmp++; if (obs_fail !== 1'b1) begin n_bad++; $display("FAIL multi_fail: got %b want 1", obs_fail); end
    n_cmp++; if (obs_idx !== 16'd3) begin n_bad++; $display("FAIL multi_idx: got %0d want 3", obs_idx); end
    clear_mask();
    n = $urandom_range(1, 12);
    run_capture(n, 1'b0, 40'd0, 1'b0);
    n_cmp++; if (obs_fail !== 1'b0 || obs_idx !== 16'd0) begin n_bad++; $display("FAIL clean_restart: got %b idx %0d want 0 0", obs_fail, obs_idx); end
    n_cmp++; if (done_cyc !== n + LAT + 1) begin n_bad++; $display("FAIL clean_done_cycle: got %0d want %0d", done_cyc, n + LAT + 1); end
    for (int k = 0; k < n; k++) begin
      n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL clean_vec%0d: got %h want %h", k, obs_vec[k], exp_q[k]); end
    end
  endtask

  task automatic test_random_runs();
    int n;
    bit ld;
    logic [39:0] sd;
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 30);
      ld = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 3) == 0) ? 40'd0 : {8'($urandom), $urandom};
      for (int i = 0; i < 64; i++) bad_mask[i] = ($urandom_range(0, 7) == 0);
      run_capture(n, ld, sd, 1'b1);
      for (int k = 0; k < n; k++) begin
        n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL rand%0d_vec%0d: got %h want %h", r, k, obs_vec[k], exp_q[k]); end
      end
      n_cmp++; if (done_cyc !== n + LAT + 1) begin n_bad++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", r, done_cyc, n + LAT + 1); end
      n_cmp++; if (obs_fail !== exp_fail) begin n_bad++; $display("FAIL rand%0d_fail: got %b want %b", r, obs_fail, exp_fail); end
      if (exp_fail) begin
        n_cmp++; if (obs_idx !== 16'(exp_idx)) begin n_bad++; $display("FAIL rand%0d_idx: got %0d want %0d", r, obs_idx, exp_idx); end
      end
      n_cmp++; if (obs_cnt_final !== 16'(n)) begin n_bad++; $display("FAIL rand%0d_cnt: got %0d want %0d", r, obs_cnt_final, n); end
    end
  endtask

  task automatic test_reset_mid_run();
    int guard;
    clear_mask();
    num_vec = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (vec_cnt !== 16'd5 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (vec_cnt !== 16'd5) begin n_bad++; $display("FAIL midrst_reach: got cnt %0d want 5", vec_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (cur_wires() !== 33'd0) begin n_bad++; $display("FAIL midrst_wires: got %h want 0", cur_wires()); end
    n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags: got %b want 000", {busy, done, fail}); end
    n_cmp++; if ({fail_idx, vec_cnt} !== 32'd0) begin n_bad++; $display("FAIL midrst_counts: got idx %0d cnt %0d want 0", fail_idx, vec_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lfsr = '1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL midrst_idle: got busy/done %b want 00", {busy, done}); end
    run_capture(3, 1'b0, 40'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (obs_vec[k] !== exp_q[k]) begin n_bad++; $display("FAIL postrst_vec%0d: got %h want %h", k, obs_vec[k], exp_q[k]); end
    end
    n_cmp++; if (done_cyc !== 3 + LAT + 1) begin n_bad++; $display("FAIL postrst_done_cycle: got %0d want %0d", done_cyc, 3 + LAT + 1); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_seed();
    test_single_mismatch();
    test_zero_count();
    test_multi_mismatch();
    test_random_runs();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
